// File: rtl/regfile_test_monitor.sv
// regfile_test_monitor: shadows the register file and, on each test-flag write,
// checks that test's programmable table of expected register values.
module regfile_test_monitor #(
  parameter int unsigned NUM_TESTS       = 64,
  parameter int unsigned CHECKS_PER_TEST = 4,
  parameter int unsigned FLAG_REG        = 20,
  parameter int unsigned TIMEOUT_CYCLES  = 100000,
  localparam int unsigned DEPTH = NUM_TESTS * CHECKS_PER_TEST,
  localparam int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned SW    = (CHECKS_PER_TEST > 1) ? $clog2(CHECKS_PER_TEST) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wb_we,
  input  logic [4:0]    wb_addr,
  input  logic [31:0]   wb_data,
  input  logic          tbl_we,
  input  logic [IW-1:0] tbl_addr,
  input  logic          tbl_valid,
  input  logic [4:0]    tbl_reg,
  input  logic [31:0]   tbl_mask,
  input  logic [31:0]   tbl_value,
  output logic          busy,
  output logic          pass,
  output logic          fail,
  output logic [1:0]    fail_code,
  output logic [7:0]    fail_test,
  output logic [SW-1:0] fail_slot,
  output logic [4:0]    fail_reg,
  output logic [31:0]   fail_got,
  output logic [31:0]   fail_exp,
  output logic [7:0]    tests_passed
);

  localparam int unsigned KW = 8;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_FAIL, S_DONE} state_e;

  typedef struct packed {
    logic [4:0]  rg;
    logic [31:0] mask;
    logic [31:0] value;
  } tbl_ent_t;

  state_e          state_q, state_d;
  logic [31:0]     shadow_q [32];
  logic [DEPTH-1:0] tvalid_q;
  tbl_ent_t        tdata_q [DEPTH];

  tbl_ent_t        ent_q, ent_d;
  logic            ent_v_q, ent_v_d;
  logic [KW-1:0]   last_k_q, last_k_d, acc_k_q, acc_k_d, cur_k_q, cur_k_d, pend_k_q, pend_k_d;
  logic            pend_q, pend_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [31:0]     wd_q, wd_d;

  logic            busy_q, busy_d, pass_q, pass_d, fail_q, fail_d;
  logic [1:0]      code_q, code_d;
  logic [KW-1:0]   ftest_q, ftest_d, passed_q, passed_d;
  logic [SW-1:0]   fslot_q, fslot_d;
  logic [4:0]      freg_q, freg_d;
  logic [31:0]     fgot_q, fgot_d, fexp_q, fexp_d;

  logic            start_c;
  logic [KW-1:0]   k_start_c;
  logic [31:0]     rd_idx_c;
  logic [IW-1:0]   rd_sel_c;

  // Flag classification and slot evaluation
  logic        active_c, flag_c, dup_c, seq_ok_c, ovf_c, seq_err_c, accept_c;
  logic [31:0] got_c;
  logic        mism_c, last_slot_c, chk_ok_c, done_c, timeout_c;

  assign active_c    = (state_q == S_IDLE) || (state_q == S_CHECK);
  assign flag_c      = wb_we && (wb_addr == 5'(FLAG_REG)) && active_c;
  assign dup_c       = (wb_data == 32'(acc_k_q));
  assign seq_ok_c    = (wb_data == 32'(acc_k_q) + 32'd1) && (wb_data <= 32'(NUM_TESTS));
  assign ovf_c       = flag_c && !dup_c && seq_ok_c && (state_q == S_CHECK) && pend_q;
  assign seq_err_c   = flag_c && !dup_c && (!seq_ok_c || ovf_c);
  assign accept_c    = flag_c && !dup_c && seq_ok_c && !ovf_c;
  assign got_c       = shadow_q[ent_q.rg];
  assign mism_c      = (state_q == S_CHECK) && ent_v_q &&
                       (((got_c ^ ent_q.value) & ent_q.mask) != 32'd0);
  assign last_slot_c = (slot_q == SW'(CHECKS_PER_TEST - 1));
  assign chk_ok_c    = (state_q == S_CHECK) && !mism_c && !seq_err_c;
  assign done_c      = chk_ok_c && last_slot_c;
  assign timeout_c   = (state_q == S_IDLE) && !accept_c && !seq_err_c &&
                       (wd_q + 32'd1 >= 32'(TIMEOUT_CYCLES));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; FAIL and DONE hold until reset
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept_c)                     state_d = S_CHECK;
        else if (seq_err_c || timeout_c)  state_d = S_FAIL;
      end
      S_CHECK: begin
        if (mism_c || seq_err_c)          state_d = S_FAIL;
        else if (done_c) begin
          if (cur_k_q == KW'(NUM_TESTS))  state_d = S_DONE;
          else if (pend_q || accept_c)    state_d = S_CHECK;
          else                            state_d = S_IDLE;
        end
      end
      default: state_d = state_q;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    ent_d    = ent_q;    ent_v_d  = ent_v_q;
    last_k_d = last_k_q; acc_k_d  = acc_k_q;
    cur_k_d  = cur_k_q;  pend_k_d = pend_k_q; pend_d = pend_q;
    slot_d   = slot_q;   wd_d     = wd_q;
    pass_d   = pass_q;   fail_d   = fail_q;   code_d = code_q;
    ftest_d  = ftest_q;  fslot_d  = fslot_q;  freg_d = freg_q;
    fgot_d   = fgot_q;   fexp_d   = fexp_q;   passed_d = passed_q;
    start_c   = 1'b0;
    k_start_c = cur_k_q;

    // Launch a check: fresh flag from IDLE, or next test right after completion
    if ((state_q == S_IDLE) && accept_c) begin
      start_c = 1'b1; k_start_c = KW'(wb_data);
    end else if (done_c) begin
      if (pend_q) begin
        start_c = 1'b1; k_start_c = pend_k_q; pend_d = 1'b0;
      end else if (accept_c) begin
        start_c = 1'b1; k_start_c = KW'(wb_data);
      end
    end else if ((state_q == S_CHECK) && accept_c) begin
      pend_d = 1'b1; pend_k_d = KW'(wb_data);
    end

    if (accept_c) begin
      acc_k_d = KW'(wb_data);
      wd_d    = 32'd0;
    end else if (state_q == S_IDLE) begin
      wd_d = wd_q + 32'd1;
    end

    // Prefetch the entry for the next evaluated slot so same-cycle table writes are not seen
    rd_idx_c = start_c ? (32'(k_start_c) - 32'd1) * 32'(CHECKS_PER_TEST)
                       : (32'(cur_k_q) - 32'd1) * 32'(CHECKS_PER_TEST) + 32'(slot_q) + 32'd1;
    rd_sel_c = (rd_idx_c < 32'(DEPTH)) ? IW'(rd_idx_c) : '0;
    if (start_c) begin
      cur_k_d = k_start_c;
      slot_d  = '0;
      ent_d   = tdata_q[rd_sel_c];
      ent_v_d = tvalid_q[rd_sel_c];
    end else if (chk_ok_c && !last_slot_c) begin
      slot_d  = slot_q + SW'(1);
      ent_d   = tdata_q[rd_sel_c];
      ent_v_d = tvalid_q[rd_sel_c];
    end

    if (done_c) begin
      last_k_d = cur_k_q;
      passed_d = passed_q + KW'(1);
      if (cur_k_q == KW'(NUM_TESTS)) pass_d = 1'b1;
    end

    // Failure capture; only reachable from IDLE/CHECK, so the first one sticks
    if (mism_c) begin
      fail_d = 1'b1; code_d = 2'd1; ftest_d = cur_k_q; fslot_d = slot_q;
      freg_d = ent_q.rg; fgot_d = got_c; fexp_d = ent_q.value; pend_d = 1'b0;
    end else if (seq_err_c) begin
      fail_d = 1'b1; code_d = 2'd2; ftest_d = KW'(wb_data); pend_d = 1'b0;
    end else if (timeout_c) begin
      fail_d = 1'b1; code_d = 2'd3; ftest_d = last_k_q + KW'(1); pend_d = 1'b0;
    end

    busy_d = (state_d == S_CHECK) || pend_d;
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q <= '0; ent_v_q <= 1'b0;
      last_k_q <= '0; acc_k_q <= '0; cur_k_q <= '0; pend_k_q <= '0; pend_q <= 1'b0;
      slot_q <= '0; wd_q <= '0;
      busy_q <= 1'b0; pass_q <= 1'b0; fail_q <= 1'b0; code_q <= '0;
      ftest_q <= '0; fslot_q <= '0; freg_q <= '0; fgot_q <= '0; fexp_q <= '0; passed_q <= '0;
    end else begin
      ent_q <= ent_d; ent_v_q <= ent_v_d;
      last_k_q <= last_k_d; acc_k_q <= acc_k_d; cur_k_q <= cur_k_d; pend_k_q <= pend_k_d;
      pend_q <= pend_d; slot_q <= slot_d; wd_q <= wd_d;
      busy_q <= busy_d; pass_q <= pass_d; fail_q <= fail_d; code_q <= code_d;
      ftest_q <= ftest_d; fslot_q <= fslot_d; freg_q <= freg_d; fgot_q <= fgot_d;
      fexp_q <= fexp_d; passed_q <= passed_d;
    end
  end

  // Shadow register file; x0 is never written so it reads 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) shadow_q[i] <= '0;
    end else if (wb_we && (wb_addr != 5'd0)) begin
      shadow_q[wb_addr] <= wb_data;
    end
  end

  // Table valid bits are reset; payload is not
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      tvalid_q <= '0;
    else if (tbl_we) tvalid_q[tbl_addr] <= tbl_valid;
  end

  // Table payload storage
  always_ff @(posedge clk) begin
    if (tbl_we) tdata_q[tbl_addr] <= tbl_ent_t'{rg: tbl_reg, mask: tbl_mask, value: tbl_value};
  end

  assign busy         = busy_q;
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign fail_code    = code_q;
  assign fail_test    = ftest_q;
  assign fail_slot    = fslot_q;
  assign fail_reg     = freg_q;
  assign fail_got     = fgot_q;
  assign fail_exp     = fexp_q;
  assign tests_passed = passed_q;

endmodule
